perf_laten_arb: RTL and testbench

//  Shares one per-flow-class latency accumulator between NUM_SRC timestamped descriptor sources.
//  A round-robin arbiter accepts at most one sample per cycle and computes latency = timestamp - ts.

---
 rtl/perf_laten_arb.sv | 210 +++++++++++++++++++++
 tb/tb_perf_laten_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/perf_laten_arb.sv
// perf_laten_arb: round-robin latency sampler feeding one shared bank of
// per-class sum/count buckets, with host snapshot reads and window dumps.
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 16
`endif

module perf_laten_arb #(
  parameter int NUM_SRC   = 4,
  parameter int TS_WIDTH  = `PANIC_DESC_TS_SIZE,
  parameter int NUM_CLASS = 5,
  parameter int SUM_WIDTH = 64,
  parameter int CNT_WIDTH = 32,
  parameter int WINDOW    = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TS_WIDTH-1:0]         timestamp,
  input  logic [NUM_SRC-1:0]          s_valid,
  output logic [NUM_SRC-1:0]          s_ready,
  input  logic [NUM_SRC*TS_WIDTH-1:0] s_ts,
  input  logic [NUM_SRC*5-1:0]        s_class,
  input  logic                        rd_req,
  input  logic [4:0]                  rd_class,
  input  logic                        rd_clear,
  output logic                        rd_ack,
  output logic [SUM_WIDTH-1:0]        rd_sum,
  output logic [CNT_WIDTH-1:0]        rd_cnt,
  output logic                        win_valid,
  output logic [4:0]                  win_class,
  output logic [SUM_WIDTH-1:0]        win_sum,
  output logic [CNT_WIDTH-1:0]        win_cnt,
  output logic [31:0]                 drop_cnt
);

  localparam int PW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t               state_q;
  logic [PW-1:0]        rr_ptr_q;
  logic                 s1_vld_q;
  logic [TS_WIDTH-1:0]  s1_lat_q;
  logic [4:0]           s1_cls_q;
  logic [4:0]           rd_cls_q;
  logic                 rd_clr_q;
  logic                 rd_ack_q;
  logic [SUM_WIDTH-1:0] rd_sum_q;
  logic [CNT_WIDTH-1:0] rd_cnt_q;
  logic                 win_valid_q;
  logic [4:0]           win_class_q;
  logic [SUM_WIDTH-1:0] win_sum_q;
  logic [CNT_WIDTH-1:0] win_cnt_q;
  logic [31:0]          drop_q;
  logic [SUM_WIDTH-1:0] sum_q [NUM_CLASS];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CLASS];

  logic [NUM_SRC-1:0]   gnt_oh;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        j;
  logic                 found;
  logic                 xfer;
  logic [PW-1:0]        rr_ptr_d;
  logic [TS_WIDTH-1:0]  sel_ts;
  logic [4:0]           sel_cls;
  logic                 s1_drop;
  logic [SUM_WIDTH-1:0] cur_sum;
  logic [CNT_WIDTH-1:0] cur_cnt;
  logic [SUM_WIDTH-1:0] nxt_sum;
  logic [CNT_WIDTH-1:0] nxt_cnt;
  logic                 win_hit;
  logic [SUM_WIDTH-1:0] rd_sel_sum;
  logic [CNT_WIDTH-1:0] rd_sel_cnt;

  // First valid source at or above rr_ptr, wrapping
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = PW'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!found && s_valid[j]) begin
        found     = 1'b1;
        gnt_oh[j] = 1'b1;
        gnt_idx   = j;
      end
    end
  end

  assign s_ready = (state_q == IDLE && !rd_req && !rst)
                 ? gnt_oh : '0;
  assign xfer    = |s_ready;
  assign sel_ts  = s_ts[gnt_idx*TS_WIDTH +: TS_WIDTH];
  assign sel_cls = s_class[gnt_idx*5 +: 5];
  assign rr_ptr_d = (gnt_idx == PW'(NUM_SRC - 1))
                  ? '0 : gnt_idx + 1'b1;

  assign s1_drop = {1'b0, s1_cls_q} >= 6'(NUM_CLASS);

  always_comb begin
    cur_sum    = '0;
    cur_cnt    = '0;
    rd_sel_sum = '0;
    rd_sel_cnt = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (s1_cls_q == 5'(c)) begin
        cur_sum = sum_q[c];
        cur_cnt = cnt_q[c];
      end
      if (rd_cls_q == 5'(c)) begin
        rd_sel_sum = sum_q[c];
        rd_sel_cnt = cnt_q[c];
      end
    end
  end

  assign nxt_sum = cur_sum + SUM_WIDTH'(s1_lat_q);
  assign nxt_cnt = cur_cnt + 1'b1;
  assign win_hit = (WINDOW != 0) && !s1_drop
                && (nxt_cnt == CNT_WIDTH'(WINDOW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_lat_q    <= '0;
      s1_cls_q    <= '0;
      rd_cls_q    <= '0;
      rd_clr_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_sum_q    <= '0;
      rd_cnt_q    <= '0;
      win_valid_q <= 1'b0;
      win_class_q <= '0;
      win_sum_q   <= '0;
      win_cnt_q   <= '0;
      drop_q      <= '0;
      for (int c = 0; c < NUM_CLASS; c++) begin
        sum_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      rd_ack_q    <= 1'b0;
      win_valid_q <= 1'b0;
      s1_vld_q    <= xfer;
      if (xfer) begin
        s1_lat_q <= timestamp - sel_ts;
        s1_cls_q <= sel_cls;
        rr_ptr_q <= rr_ptr_d;
      end
      if (s1_vld_q) begin
        if (s1_drop) begin
          if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end else if (win_hit) begin
          win_valid_q <= 1'b1;
          win_class_q <= s1_cls_q;
          win_sum_q   <= nxt_sum;
          win_cnt_q   <= nxt_cnt;
        end
        for (int c = 0; c < NUM_CLASS; c++) begin
          if (!s1_drop && s1_cls_q == 5'(c)) begin
            sum_q[c] <= win_hit ? '0 : nxt_sum;
            cnt_q[c] <= win_hit ? '0 : nxt_cnt;
          end
        end
      end
      unique case (state_q)
        IDLE: begin
          if (rd_req) begin
            rd_cls_q <= rd_class;
            rd_clr_q <= rd_clear;
            state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rd_ack_q <= 1'b1;
          rd_sum_q <= rd_sel_sum;
          rd_cnt_q <= rd_sel_cnt;
          state_q  <= RD_RESP;
        end
        RD_RESP: begin
          // Arbiter is held off since RD_WAIT, so no commit races this clear
          for (int c = 0; c < NUM_CLASS; c++) begin
            if (rd_clr_q && rd_cls_q == 5'(c)) begin
              sum_q[c] <= '0;
              cnt_q[c] <= '0;
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_ack    = rd_ack_q;
  assign rd_sum    = rd_sum_q;
  assign rd_cnt    = rd_cnt_q;
  assign win_valid = win_valid_q;
  assign win_class = win_class_q;
  assign win_sum   = win_sum_q;
  assign win_cnt   = win_cnt_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_perf_laten_arb.sv
// tb_perf_laten_arb: directed vectors and hand-written sequences
// for the shared latency accumulator.
module tb_perf_laten_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] timestamp;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [63:0] s_ts;
  logic [19:0] s_class;
  logic        rd_req;
  logic [4:0]  rd_class;
  logic        rd_clear;
  logic        rd_ack;
  logic [63:0] rd_sum;
  logic [31:0] rd_cnt;
  logic        win_valid;
  logic [4:0]  win_class;
  logic [63:0] win_sum;
  logic [31:0] win_cnt;
  logic [31:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int win_pulses = 0;
  int acks;

  perf_laten_arb dut (
    .clk(clk), .rst(rst), .timestamp(timestamp),
    .s_valid(s_valid), .s_ready(s_ready), .s_ts(s_ts),
    .s_class(s_class), .rd_req(rd_req), .rd_class(rd_class),
    .rd_clear(rd_clear), .rd_ack(rd_ack), .rd_sum(rd_sum),
    .rd_cnt(rd_cnt), .win_valid(win_valid),
    .win_class(win_class), .win_sum(win_sum),
    .win_cnt(win_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (win_valid) win_pulses++;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] exp_rdy;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int src, input logic [4:0] cls,
                      input logic [15:0] ts);
    @(negedge clk);
    s_valid = 4'(1 << src);
    s_class[src*5 +: 5] = cls;
    s_ts[src*16 +: 16] = ts;
    #1 chk("send_ready", 64'(s_ready), 64'(1 << src));
  endtask

  task automatic do_read(input logic [4:0] cls, input logic clr,
                         input logic [63:0] es, input logic [31:0] ec,
                         input string nm);
    @(negedge clk);
    s_valid  = '0;
    rd_req   = 1'b1;
    rd_class = cls;
    rd_clear = clr;
    @(negedge clk);
    rd_req = 1'b0;
    chk({nm, "_ack_early"}, 64'(rd_ack), 64'd0);
    @(negedge clk);
    chk({nm, "_ack"}, 64'(rd_ack), 64'd1);
    chk({nm, "_sum"}, rd_sum, es);
    chk({nm, "_cnt"}, 64'(rd_cnt), 64'(ec));
    @(negedge clk);
    chk({nm, "_ack_fall"}, 64'(rd_ack), 64'd0);
  endtask

  initial begin
    // rr_ptr starts at 0; expected grants hand-traced
    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b1111, 4'b0010};
    vecs[6]  = '{4'b1111, 4'b0100};
    vecs[7]  = '{4'b1111, 4'b1000};
    vecs[8]  = '{4'b1010, 4'b0010};
    vecs[9]  = '{4'b1010, 4'b1000};
    vecs[10] = '{4'b0000, 4'b0000};
    vecs[11] = '{4'b0101, 4'b0001};
    vecs[12] = '{4'b0101, 4'b0100};
    vecs[13] = '{4'b0001, 4'b0001};

    rst = 1'b1;
    timestamp = 16'd1000;
    s_valid = 4'b1111;
    s_ts = '0;
    s_class = '0;
    rd_req = 1'b0;
    rd_class = '0;
    rd_clear = 1'b0;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_rd_ack", 64'(rd_ack), 64'd0);
    chk("rst_rd_sum", rd_sum, 64'd0);
    chk("rst_win_valid", 64'(win_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    s_valid = '0;
    rst = 1'b0;

    // Round robin: src i carries class 4, latency i+1
    for (int i = 0; i < 4; i++) begin
      s_class[i*5 +: 5] = 5'd4;
      s_ts[i*16 +: 16] = timestamp - 16'(i + 1);
    end
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      s_valid = vecs[v].vld;
      #1 chk($sformatf("rr_vec%0d", v), 64'(s_ready),
             64'(vecs[v].exp_rdy));
    end
    // 8*2.5 + 2+4+1+3+1 = 31 over 13 grants
    do_read(5'd4, 1'b1, 64'd31, 32'd13, "rr_bucket");
    do_read(5'd4, 1'b0, 64'd0, 32'd0, "rr_cleared");

    // Three samples, latency 10
    for (int n = 0; n < 3; n++) send(0, 5'd2, 16'd990);
    do_read(5'd2, 1'b0, 64'd30, 32'd3, "cls2");

    // Read collides with a pending sample
    @(negedge clk);
    rd_req = 1'b1;
    rd_class = 5'd2;
    rd_clear = 1'b0;
    s_valid = 4'b0001;
    s_ts[15:0] = 16'd993;
    #1 chk("coll_rdy_req", 64'(s_ready), 64'd0);
    @(negedge clk);
    rd_req = 1'b0;
    #1 chk("coll_rdy_wait", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("coll_ack", 64'(rd_ack), 64'd1);
    chk("coll_sum", rd_sum, 64'd30);
    chk("coll_cnt", 64'(rd_cnt), 64'd3);
    #1 chk("coll_rdy_resp", 64'(s_ready), 64'd0);
    @(negedge clk);
    #1 chk("coll_rdy_after", 64'(s_ready), 64'd1);
    do_read(5'd2, 1'b0, 64'd37, 32'd4, "coll_late");

    // Dropped class, then timestamp wrap
    send(0, 5'd7, 16'd991);
    @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    chk("drop_cnt", 64'(drop_cnt), 64'd1);
    do_read(5'd2, 1'b0, 64'd37, 32'd4, "drop_keep");
    do_read(5'd7, 1'b0, 64'd0, 32'd0, "oob_read");
    timestamp = 16'd3;
    send(1, 5'd1, 16'hFFFE);
    do_read(5'd1, 1'b0, 64'd5, 32'd1, "wrap");

    // Full window on class 0
    timestamp = 16'd1000;
    for (int n = 0; n < 128; n++) send(0, 5'd0, 16'd996);
    @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("win_pulses", 64'(win_pulses), 64'd1);
    chk("win_sum", win_sum, 64'd512);
    chk("win_cnt", 64'(win_cnt), 64'd128);
    chk("win_class", 64'(win_class), 64'd0);
    chk("win_valid_low", 64'(win_valid), 64'd0);
    do_read(5'd0, 1'b0, 64'd0, 32'd0, "win_reset");
    chk("win_hold", win_sum, 64'd512);

    // Reset between rd_req and rd_ack
    @(negedge clk);
    rd_req = 1'b1;
    rd_class = 5'd2;
    s_valid = 4'b1111;
    @(negedge clk);
    rd_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_s_ready", 64'(s_ready), 64'd0);
    chk("arst_rd_ack", 64'(rd_ack), 64'd0);
    chk("arst_win_sum", win_sum, 64'd0);
    chk("arst_win_cnt", 64'(win_cnt), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    acks = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        rst = 1'b0;
        s_valid = '0;
      end
      if (rd_ack) acks++;
    end
    chk("arst_no_ack", 64'(acks), 64'd0);
    do_read(5'd2, 1'b0, 64'd0, 32'd0, "arst_bucket");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
